// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch flushes,
// data-memory wait freezes with a timeout watchdog, and a saturating stall counter.
module pipe_hazard_ctrl #(
    parameter int REGW       = 5,
    parameter int TMO_CYCLES = 64,
    parameter int CNTW       = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [REGW-1:0] id_rs1,
    input  logic [REGW-1:0] id_rs2,
    input  logic            id_uses_rs2,
    input  logic [REGW-1:0] ex_rd,
    input  logic            ex_mem_read,
    input  logic            ex_branch_taken,
    input  logic            mem_req,
    input  logic            mem_ready,
    output logic            pc_load,
    output logic            ifid_load,
    output logic            ifid_flush,
    output logic            idex_load,
    output logic            idex_flush,
    output logic            exmem_load,
    output logic            memwb_flush,
    output logic            mem_err,
    output logic [CNTW-1:0] stall_cnt,
    output logic [1:0]      state
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    localparam int TW = $clog2(TMO_CYCLES) + 1;

    state_t          state_q, state_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;

    logic load_use;
    logic freeze;
    logic halted;
    logic eval_rules;

    assign load_use = ex_mem_read && (ex_rd != '0) &&
                      ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));

    always_comb begin
        state_d    = state_q;
        tmo_d      = tmo_q;
        err_d      = err_q;
        freeze     = 1'b0;
        halted     = 1'b0;
        eval_rules = 1'b0;

        case (state_q)
            RUN: begin
                if (mem_req && !mem_ready) begin
                    freeze  = 1'b1;
                    state_d = MEM_WAIT;
                    tmo_d   = TW'(1);
                end else begin
                    eval_rules = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (!mem_ready) begin
                    freeze = 1'b1;
                    if (tmo_q == TW'(TMO_CYCLES - 1)) begin
                        state_d = HALT;
                        err_d   = 1'b1;
                    end else begin
                        tmo_d = tmo_q + TW'(1);
                    end
                end else begin
                    eval_rules = 1'b1;
                    state_d    = RUN;
                    tmo_d      = '0;
                end
            end
            HALT:    halted  = 1'b1;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        pc_load     = 1'b1;
        ifid_load   = 1'b1;
        ifid_flush  = 1'b0;
        idex_load   = 1'b1;
        idex_flush  = 1'b0;
        exmem_load  = 1'b1;
        memwb_flush = 1'b0;

        if (!rst_n) begin
            pc_load     = 1'b0;
            ifid_load   = 1'b0;
            ifid_flush  = 1'b1;
            idex_load   = 1'b0;
            idex_flush  = 1'b1;
            exmem_load  = 1'b0;
            memwb_flush = 1'b1;
        end else if (freeze || halted) begin
            pc_load     = 1'b0;
            ifid_load   = 1'b0;
            idex_load   = 1'b0;
            exmem_load  = 1'b0;
            memwb_flush = freeze;
        end else if (eval_rules) begin
            // Branch outranks load-use: the dependent instruction is being flushed anyway.
            if (ex_branch_taken) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (load_use) begin
                pc_load    = 1'b0;
                ifid_load  = 1'b0;
                idex_flush = 1'b1;
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (!pc_load && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            tmo_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign mem_err   = err_q;
    assign stall_cnt = cnt_q;
    assign state     = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios then random traffic, all checked
// against a cycle-level behavioural model of the sequencing rules.
module tb_pipe_hazard_ctrl;

    localparam int REGW  = 5;
    localparam int TMO   = 4;
    localparam int CNTW  = 4;
    localparam int CMAX  = (1 << CNTW) - 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [REGW-1:0] id_rs1, id_rs2, ex_rd;
    logic            id_uses_rs2, ex_mem_read, ex_branch_taken, mem_req, mem_ready;
    logic            pc_load, ifid_load, ifid_flush, idex_load, idex_flush, exmem_load, memwb_flush;
    logic            mem_err;
    logic [CNTW-1:0] stall_cnt;
    logic [1:0]      state;

    int checks = 0;
    int errors = 0;

    // Reference model: 0=RUN 1=MEM_WAIT 2=HALT, wait counter, stall count, sticky error
    int m_st, m_tmo, m_cnt;
    bit m_err;

    pipe_hazard_ctrl #(.REGW(REGW), .TMO_CYCLES(TMO), .CNTW(CNTW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_load(pc_load), .ifid_load(ifid_load), .ifid_flush(ifid_flush),
        .idex_load(idex_load), .idex_flush(idex_flush), .exmem_load(exmem_load),
        .memwb_flush(memwb_flush), .mem_err(mem_err), .stall_cnt(stall_cnt), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Vector order: pc_load ifid_load ifid_flush idex_load idex_flush exmem_load memwb_flush
    function automatic logic [6:0] expect_sel(input bit lu);
        bit waiting;
        waiting = (m_st == 0 && mem_req && !mem_ready) || (m_st == 1 && !mem_ready);
        if (m_st == 2)            return 7'b0000000;
        if (waiting)              return 7'b0000001;
        if (ex_branch_taken)      return 7'b1111110;
        if (lu)                   return 7'b0001110;
        return 7'b1101010;
    endfunction

    function automatic logic [6:0] dut_sel();
        return {pc_load, ifid_load, ifid_flush, idex_load, idex_flush, exmem_load, memwb_flush};
    endfunction

    task automatic cyc(input logic [REGW-1:0] rs1, input logic [REGW-1:0] rs2, input bit u2,
                       input logic [REGW-1:0] rd, input bit mr, input bit br,
                       input bit mq, input bit my, input string tag);
        bit lu;
        logic [6:0] exp;
        id_rs1 = rs1; id_rs2 = rs2; id_uses_rs2 = u2; ex_rd = rd;
        ex_mem_read = mr; ex_branch_taken = br; mem_req = mq; mem_ready = my;
        #1;
        lu  = mr && (rd != 0) && (rd == rs1 || (u2 && rd == rs2));
        exp = expect_sel(lu);
        chk({tag, ".sel"}, 32'(dut_sel()), 32'(exp));
        chk({tag, ".state"}, 32'(state), 32'(m_st));
        chk({tag, ".cnt"}, 32'(stall_cnt), 32'(m_cnt));
        chk({tag, ".err"}, 32'(mem_err), 32'(m_err));
        if (exp[6] == 1'b0 && m_cnt < CMAX) m_cnt++;
        case (m_st)
            0: if (mq && !my) begin m_st = 1; m_tmo = 1; end
            1: if (my) begin m_st = 0; m_tmo = 0; end
               else if (m_tmo == TMO - 1) begin m_st = 2; m_err = 1; end
               else m_tmo++;
            default: ;
        endcase
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        chk({tag, ".rst_sel"}, 32'(dut_sel()), 32'(7'b0010101));
        chk({tag, ".rst_state"}, 32'(state), 32'd0);
        chk({tag, ".rst_cnt"}, 32'(stall_cnt), 32'd0);
        chk({tag, ".rst_err"}, 32'(mem_err), 32'd0);
        m_st = 0; m_tmo = 0; m_cnt = 0; m_err = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        id_rs1 = '0; id_rs2 = '0; id_uses_rs2 = 0; ex_rd = '0;
        ex_mem_read = 0; ex_branch_taken = 0; mem_req = 0; mem_ready = 0;
        @(negedge clk);

        do_reset("reset");
        cyc(5'd1, 5'd2, 1, 5'd3, 0, 0, 0, 0, "idle");
        chk("idle_loads", 32'({pc_load, ifid_load, idex_load, exmem_load}), 32'hf);

        cyc(5'd5, 5'd1, 0, 5'd5, 1, 0, 0, 0, "lu_rs1");
        chk("lu_cnt", 32'(stall_cnt), 32'd1);
        cyc(5'd2, 5'd5, 0, 5'd5, 1, 0, 0, 0, "lu_rs2_unused");
        cyc(5'd2, 5'd5, 1, 5'd5, 1, 0, 0, 0, "lu_rs2");
        cyc(5'd0, 5'd0, 1, 5'd0, 1, 0, 0, 0, "lu_rd0");
        chk("rd0_cnt", 32'(stall_cnt), 32'd2);

        cyc(5'd5, 5'd1, 0, 5'd5, 1, 1, 0, 0, "br_lu");
        chk("br_lu_cnt", 32'(stall_cnt), 32'd2);

        do_reset("mw");
        for (int i = 0; i < 3; i++) begin
            cyc(5'd1, 5'd2, 0, 5'd3, 0, 0, 1, 0, "mw_wait");
            chk("mw_state", 32'(state), 32'd1);
        end
        cyc(5'd1, 5'd2, 0, 5'd3, 0, 0, 1, 1, "mw_done");
        chk("mw_state_end", 32'(state), 32'd0);
        chk("mw_cnt", 32'(stall_cnt), 32'd3);

        do_reset("tmo");
        for (int i = 0; i < 4; i++) cyc(5'd1, 5'd2, 0, 5'd3, 0, 0, 1, 0, "tmo_wait");
        chk("tmo_state", 32'(state), 32'd2);
        chk("tmo_err", 32'(mem_err), 32'd1);
        for (int i = 0; i < 3; i++) cyc(5'd1, 5'd2, 0, 5'd3, 0, 1, 0, 1, "halt_hold");
        chk("halt_state", 32'(state), 32'd2);

        do_reset("sat");
        for (int i = 0; i < 20; i++) cyc(5'd7, 5'd2, 0, 5'd7, 1, 0, 0, 0, "sat_lu");
        chk("sat_cnt", 32'(stall_cnt), 32'(CMAX));
        do_reset("sat2");
        cyc(5'd1, 5'd2, 0, 5'd3, 0, 0, 1, 0, "mid_mw");
        cyc(5'd1, 5'd2, 0, 5'd3, 0, 0, 0, 0, "mid_mw2");
        chk("mid_mw_state", 32'(state), 32'd1);
        do_reset("mid_mw_rst");
        chk("after_rst_state", 32'(state), 32'd0);

        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 59) == 0 || (m_st == 2 && $urandom_range(0, 3) == 0))
                do_reset("rnd");
            cyc(REGW'($urandom_range(0, 3)), REGW'($urandom_range(0, 3)), 1'($urandom),
                REGW'($urandom_range(0, 3)), 1'($urandom), ($urandom_range(0, 4) == 0),
                ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) != 0), "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
